piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter built from the NAND-based storage library.

---
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer -- parallel-in / serial-out transmitter.
//
// Loads a WIDTH-bit word when ld is seen in IDLE and shifts it out LSB first,
// one bit per falling edge of c. Frame: IDLE -> SHIFT (NBITS cycles, sv=1)
// -> DONE (one cycle, done=1) -> IDLE (at least one cycle, rdy=1).
//
// Optional feature macro: PISO_PARITY_EN
//   defined   : an even-parity bit (XOR of the data bits) follows the data as
//               frame bit WIDTH, so NBITS = WIDTH+1.
//   undefined : NBITS = WIDTH; DONE follows data bit WIDTH-1 directly.
//
// Ports
//   c    in   clock; all state changes on the falling edge
//   r    in   asynchronous active-high reset
//   d    in   parallel word, sampled only when a load is accepted
//   ld   in   load request, honoured only while rdy=1
//   rdy  out  high in IDLE
//   so   out  serial data, LSB first
//   sv   out  high while so carries a frame bit
//   done out  one-cycle pulse after the last frame bit
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  output logic             rdy,
  output logic             so,
  output logic             sv,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [NBITS-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] ld_word;

  // Parity is folded into the shift register at load time, so it simply
  // falls out as the last bit with no extra output mux.
`ifdef PISO_PARITY_EN
  assign ld_word = {^d, d};
`else
  assign ld_word = d;
`endif

  always_ff @(negedge c or posedge r) begin
    if (r) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld) begin
            sreg  <= ld_word;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sreg <= sreg >> 1;
          if (cnt == LAST) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state: no path from ld or d.
  assign rdy  = (state == S_IDLE);
  assign sv   = (state == S_SHIFT);
  assign done = (state == S_DONE);
  assign so   = sv & sreg[0];

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int TOK_DONE = 2;

  logic             c = 1'b0;
  logic             r = 1'b1;
  logic [WIDTH-1:0] d = '0;
  logic             ld = 1'b0;
  logic             rdy, so, sv, done;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .c(c), .r(r), .d(d), .ld(ld),
    .rdy(rdy), .so(so), .sv(sv), .done(done)
  );

  always #5 c = ~c;

  int q[$];
  int checks = 0;
  int errs   = 0;
  bit cont_mode = 1'b0;
  bit pd1 = 1'b0, pd2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: frame bits (0/1) followed by a done token.
  task automatic push_frame(input logic [7:0] w, input bit par, input int nbits, input bit with_done);
    for (int i = 0; i < nbits; i++) begin
      if (i < WIDTH) q.push_back(int'(w[i]));
      else           q.push_back(int'(par));
    end
    if (with_done) q.push_back(TOK_DONE);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      @(posedge c); #1;
      n++;
    end
    chk("rdy_wait", rdy, 1);
  endtask

  // Drive ld for one falling edge, then scramble d to show it is not re-sampled.
  task automatic load(input logic [7:0] w, input bit par, input int nbits, input bit with_done);
    wait_rdy();
    push_frame(w, par, nbits, with_done);
    ld = 1'b1;
    d  = w;
    @(negedge c);
    @(posedge c); #1;
    ld = 1'b0;
    d  = 8'($urandom);
  endtask

  // Monitor: samples on the rising edge, half a cycle after state changes.
  always @(posedge c) begin
    int e;
    if (!r) begin
      if (sv) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL so_unexpected: got bit %0d expected no frame bit at %0t", so, $time);
        end else begin
          e = q.pop_front();
          chk("frame_order_bit", (e == TOK_DONE), 0);
          if (e != TOK_DONE) chk("so_bit", so, e);
        end
      end else begin
        chk("so_quiet", so, 0);
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL done_unexpected: got done=1 expected 0 at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("done_token", e, TOK_DONE);
        end
      end
      chk("state_onehot", 32'(rdy) + 32'(sv) + 32'(done), 1);
      if (pd1) chk("idle_after_done", {rdy, sv}, 2'b10);
      if (cont_mode && pd2) chk("first_bit_after_gap", sv, 1);
      pd2 = pd1;
      pd1 = done;
    end else begin
      pd1 = 1'b0;
      pd2 = 1'b0;
    end
  end

  initial begin
    int n;
    // Reset values while r is held.
    #1;
    chk("reset_outs", {rdy, sv, so, done}, 4'b1000);
    @(posedge c); #1;
    ld = 1'b1;                  // ignored under reset
    @(negedge c); @(posedge c); #1;
    chk("reset_ignores_ld", {rdy, sv}, 2'b10);
    ld = 1'b0;
    r  = 1'b0;

    // 1: idle with no load.
    repeat (5) begin
      @(posedge c); #1;
      chk("idle", {rdy, sv, so, done}, 4'b1000);
    end

    // 2: A5 frame, explicit latency of done and rdy.
    load(8'hA5, 1'b0, NB, 1'b1);  // returns just after edge 0
    repeat (NB - 1) @(posedge c);
    @(posedge c); #1;
    chk("done_latency", done, 1);
    @(posedge c); #1;
    chk("rdy_latency", rdy, 1);

    // 3: parity vectors (07 has three ones -> parity 1).
    load(8'h07, 1'b1, NB, 1'b1);
    load(8'hA5, 1'b0, NB, 1'b1);

    // 4: load attempt at edge 2 of an in-flight frame is ignored.
    load(8'hA5, 1'b0, NB, 1'b1);
    @(posedge c); #1;
    ld = 1'b1; d = 8'h3C;
    @(posedge c); #1;
    ld = 1'b0;

    // 5: reset between edges 3 and 4 of an FF frame.
    load(8'hFF, 1'b0, 4, 1'b0);
    repeat (3) @(posedge c);
    #1;
    r = 1'b1;
    #1;
    chk("abort_rdy",  rdy,  1);
    chk("abort_sv",   sv,   0);
    chk("abort_so",   so,   0);
    chk("abort_done", done, 0);
    chk("abort_bits_seen", q.size(), 0);
    @(posedge c); #1;
    r = 1'b0;
    load(8'h81, 1'b0, NB, 1'b1);

    // 6: ld held high -> back-to-back frames with a one-cycle idle gap.
    wait_rdy();
    for (int f = 0; f < 3; f++) push_frame(8'hA5, 1'b0, NB, 1'b1);
    cont_mode = 1'b1;
    ld = 1'b1; d = 8'hA5;
    for (int f = 0; f < 3; f++) begin
      wait_rdy();
      @(negedge c);
      #1;
    end
    ld = 1'b0;
    cont_mode = 1'b0;

    // Drain the scoreboard.
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge c); #1;
      n++;
    end
    repeat (3) @(posedge c);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("final_idle", {rdy, sv, so, done}, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
